// File: rtl/bus_dbg_master_if.sv
// Bus types plus the command/response byte streams and bus port of bus_dbg_master,
// bundled with master (initiator) and slave (environment) views.
package bus;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } m2s_s;

  typedef struct packed {
    logic        ack;
    logic [31:0] data;
  } s2m_s;
endpackage

interface bus_dbg_master_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       rsp_ready;
  bus::m2s_s  bus_o;
  bus::s2m_s  bus_i;

  modport master (
    input  cmd_data, cmd_valid,
    output cmd_ready,
    output rsp_data, rsp_valid,
    input  rsp_ready,
    output bus_o,
    input  bus_i
  );

  modport slave (
    output cmd_data, cmd_valid,
    input  cmd_ready,
    input  rsp_data, rsp_valid,
    output rsp_ready,
    input  bus_o,
    output bus_i
  );
endinterface

// File: rtl/bus_dbg_master.sv
// Byte-stream debug initiator: 'W' addr[4] data[4] / 'R' addr[4] become single bus words.
// Optional ack watchdog enabled by defining BUS_DBG_TIMEOUT_EN.
module bus_dbg_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output bus::m2s_s  bus_o,
  input  bus::s2m_s  bus_i,
  output logic       busy
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RSP} state_e;

  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [23:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic        req_q, req_d;
  logic        multi_q, multi_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        cmd_fire, rsp_fire, ack_fire, tmo_hit;
  logic [1:0]  rsp_last;

  assign cmd_fire = cmd_valid && cmd_ready_q;
  assign rsp_fire = rsp_valid_q && rsp_ready;
  assign ack_fire = req_q && bus_i.ack;
  assign rsp_last = multi_q ? 2'd3 : 2'd0;

`ifdef BUS_DBG_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;

  assign tmo_d   = (state_q == S_BUS) ? tmo_q + 16'd1 : 16'd0;
  assign tmo_hit = (state_q == S_BUS) && !ack_fire && (tmo_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      we_q        <= 1'b0;
      req_q       <= 1'b0;
      multi_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      we_q        <= we_d;
      req_q       <= req_d;
      multi_q     <= multi_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_fire)
                state_d = (cmd_data == OP_W || cmd_data == OP_R) ? S_ADDR : S_RSP;
      S_ADDR: if (cmd_fire && cnt_q == 2'd3)
                state_d = (addr_q[1:0] != 2'b00) ? S_RSP : (we_q ? S_DATA : S_BUS);
      S_DATA: if (cmd_fire && cnt_q == 2'd3) state_d = S_BUS;
      S_BUS:  if (ack_fire || tmo_hit) state_d = S_RSP;
      S_RSP:  if (rsp_fire && cnt_q == rsp_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    we_d        = we_q;
    req_d       = 1'b0;
    multi_d     = multi_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      S_IDLE: if (cmd_fire) we_d = (cmd_data == OP_W);
      S_ADDR: if (cmd_fire) addr_d[{cnt_q, 3'b000} +: 8] = cmd_data;
      S_DATA: if (cmd_fire) wdata_d[{cnt_q, 3'b000} +: 8] = cmd_data;
      S_BUS: begin
        req_d = !(ack_fire || tmo_hit);
        if (ack_fire) rdata_d = bus_i.data[31:8];
      end
      // Remaining read bytes drain LSB first out of a shift register.
      S_RSP: if (rsp_fire) begin
        rsp_data_d = rdata_q[7:0];
        rdata_d    = {8'h00, rdata_q[23:8]};
      end
      default: ;
    endcase

    if (cmd_fire || rsp_fire) cnt_d = cnt_q + 2'd1;
    if (state_d != state_q)   cnt_d = 2'd0;

    // First response byte is presented in the same cycle RSP is entered.
    if (state_d == S_RSP && state_q != S_RSP) begin
      rsp_valid_d = 1'b1;
      multi_d     = ack_fire && !we_q;
      rsp_data_d  = !ack_fire ? NAK_BYTE : (we_q ? ACK_BYTE : bus_i.data[7:0]);
    end
    if (state_q == S_RSP && state_d == S_IDLE) rsp_valid_d = 1'b0;

    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DATA);
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign bus_o.req  = req_q;
  assign bus_o.we   = we_q;
  assign bus_o.addr = addr_q;
  assign bus_o.data = wdata_q;
  assign busy       = (state_q != S_IDLE);

endmodule
